// File: rtl/pi_link_rx.sv
// Receive side of a two-phase (tag, data) request/acknowledge byte link from an asynchronous sender.
// Optional PI_LINK_TAG_FILTER_EN: deliver only pairs whose tag is 0x70, 0x71, 0x38 or 0x39.
module pi_link_rx #(
   parameter int unsigned SETTLE   = 2,
   parameter int unsigned ACK_HOLD = 4,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  GPIO_AD,
   input  logic [1:0]  REQ,
   output logic        ACK,
   output logic [7:0]  out_tag,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        err,
   output logic [15:0] pair_cnt
);

   localparam int unsigned CW = 9;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_ACK_HI = 2'd2;
   localparam logic [1:0] ST_ACK_LO = 2'd3;

   logic [7:0]    gpio_s1, gpio_s2;
   logic [1:0]    req_s1, req_s2;
   logic [1:0]    state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic          exp_ph, exp_nxt;
   logic          cap_ph, cap_ph_nxt;
   logic          to_flag, to_nxt;
   logic [7:0]    gpio_ref, ref_nxt;
   logic [7:0]    tag_reg, tag_nxt;
   logic          ack_nxt;
   logic [7:0]    out_tag_nxt, out_data_nxt;
   logic          valid_nxt;
   logic          err_nxt;
   logic [15:0]   pcnt_nxt;
   logic          tag_pass_c;
   logic          match_c;
   logic          release_c;

`ifdef PI_LINK_TAG_FILTER_EN
   assign tag_pass_c = (tag_reg == 8'h70) || (tag_reg == 8'h71) ||
                       (tag_reg == 8'h38) || (tag_reg == 8'h39);
`else
   assign tag_pass_c = 1'b1;
`endif

   assign match_c   = (req_s2 == {exp_ph, 1'b1}) && (gpio_s2 == gpio_ref);
   assign release_c = !req_s2[0] || (req_s2[1] != cap_ph);

   // Next-state and next-output logic
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      exp_nxt      = exp_ph;
      cap_ph_nxt   = cap_ph;
      to_nxt       = to_flag;
      ref_nxt      = gpio_ref;
      tag_nxt      = tag_reg;
      ack_nxt      = ACK;
      out_tag_nxt  = out_tag;
      out_data_nxt = out_data;
      valid_nxt    = out_valid & ~out_ready;
      err_nxt      = 1'b0;
      pcnt_nxt     = pair_cnt;
      case (state)
         ST_IDLE: begin
            if (req_s2[0]) begin
               if (req_s2[1] == exp_ph) begin
                  state_nxt = ST_SETTLE;
                  cnt_nxt   = '0;
                  ref_nxt   = gpio_s2;
               end else begin
                  err_nxt = 1'b1;
                  exp_nxt = 1'b0;
                  tag_nxt = 8'h00;
               end
            end
         end
         ST_SETTLE: begin
            if (!match_c) begin
               state_nxt = ST_IDLE;
            end else if (cnt != CW'(SETTLE)) begin
               cnt_nxt = cnt + CW'(1);
            end else if (!exp_ph || !tag_pass_c || !out_valid || out_ready) begin
               // Data byte waits here, unacknowledged, while the output slot is occupied
               if (!exp_ph) begin
                  tag_nxt = gpio_ref;
               end else if (tag_pass_c) begin
                  out_tag_nxt  = tag_reg;
                  out_data_nxt = gpio_ref;
                  valid_nxt    = 1'b1;
                  pcnt_nxt     = pair_cnt + 16'd1;
               end
               state_nxt  = ST_ACK_HI;
               ack_nxt    = 1'b1;
               cnt_nxt    = '0;
               cap_ph_nxt = exp_ph;
               to_nxt     = 1'b0;
            end
         end
         ST_ACK_HI: begin
            if (release_c && (cnt >= CW'(ACK_HOLD - 1))) begin
               state_nxt = ST_ACK_LO;
               ack_nxt   = 1'b0;
               cnt_nxt   = '0;
            end else if (cnt >= CW'(TIMEOUT)) begin
               state_nxt = ST_ACK_LO;
               ack_nxt   = 1'b0;
               cnt_nxt   = '0;
               err_nxt   = 1'b1;
               exp_nxt   = 1'b0;
               tag_nxt   = 8'h00;
               to_nxt    = 1'b1;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         ST_ACK_LO: begin
            if (cnt >= CW'(ACK_HOLD - 1)) begin
               state_nxt = ST_IDLE;
               if (!to_flag) exp_nxt = ~exp_ph;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Synchronizers, FSM state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gpio_s1   <= 8'h00;
         gpio_s2   <= 8'h00;
         req_s1    <= 2'b00;
         req_s2    <= 2'b00;
         state     <= ST_IDLE;
         cnt       <= '0;
         exp_ph    <= 1'b0;
         cap_ph    <= 1'b0;
         to_flag   <= 1'b0;
         gpio_ref  <= 8'h00;
         tag_reg   <= 8'h00;
         ACK       <= 1'b0;
         out_tag   <= 8'h00;
         out_data  <= 8'h00;
         out_valid <= 1'b0;
         err       <= 1'b0;
         pair_cnt  <= 16'h0000;
      end else begin
         gpio_s1   <= GPIO_AD;
         gpio_s2   <= gpio_s1;
         req_s1    <= REQ;
         req_s2    <= req_s1;
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         exp_ph    <= exp_nxt;
         cap_ph    <= cap_ph_nxt;
         to_flag   <= to_nxt;
         gpio_ref  <= ref_nxt;
         tag_reg   <= tag_nxt;
         ACK       <= ack_nxt;
         out_tag   <= out_tag_nxt;
         out_data  <= out_data_nxt;
         out_valid <= valid_nxt;
         err       <= err_nxt;
         pair_cnt  <= pcnt_nxt;
      end
   end

endmodule

// File: tb/tb_pi_link_rx.sv
// Directed bench for pi_link_rx: a behavioural sender, a consumer monitor and per-scenario tasks.
module tb_pi_link_rx;

   logic        clk;
   logic        rst_n;
   logic [7:0]  GPIO_AD;
   logic [1:0]  REQ;
   logic        ACK;
   logic [7:0]  out_tag;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic        err;
   logic [15:0] pair_cnt;

   int n_checks = 0;
   int n_pass   = 0;
   int ack_rises = 0;
   int err_cnt   = 0;
   logic ack_d = 1'b0;
   logic [15:0] got_q[$];
   bit filt;

   pi_link_rx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .GPIO_AD   (GPIO_AD),
      .REQ       (REQ),
      .ACK       (ACK),
      .out_tag   (out_tag),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .err       (err),
      .pair_cnt  (pair_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Consumer side: record accepted pairs, error pulses and ACK rising edges
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
         got_q.push_back({out_tag, out_data});
      if (err === 1'b1) err_cnt++;
      if (ACK === 1'b1 && ack_d !== 1'b1) ack_rises++;
      ack_d = ACK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_ack(input logic lvl, output bit ok);
      int n;
      n = 0;
      while (ACK !== lvl && n < 400) begin
         @(negedge clk);
         n++;
      end
      ok = (ACK === lvl);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic ph, output bit ok);
      bit o1, o2;
      GPIO_AD = b;
      REQ     = {ph, 1'b1};
      wait_ack(1'b1, o1);
      @(posedge clk); #1;
      REQ = 2'b00;
      wait_ack(1'b0, o2);
      ok = o1 & o2;
   endtask

   task automatic send_pair(input logic [7:0] t, input logic [7:0] d, output bit ok);
      bit o1, o2;
      send_byte(t, 1'b0, o1);
      send_byte(d, 1'b1, o2);
      ok = o1 & o2;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; REQ = 2'b00; GPIO_AD = 8'h00; out_ready = 1'b1;
      #3 rst_n = 1'b0;
      cyc(3);
      n_checks++; if (ACK !== 1'b0) $display("FAIL reset_ack: got %b expected 0", ACK); else n_pass++;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", out_valid); else n_pass++;
      n_checks++; if ({out_tag, out_data} !== 16'h0000) $display("FAIL reset_outs: got %h expected 0000", {out_tag, out_data}); else n_pass++;
      n_checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b expected 0", err); else n_pass++;
      n_checks++; if (pair_cnt !== 16'h0000) $display("FAIL reset_cnt: got %h expected 0000", pair_cnt); else n_pass++;
      rst_n = 1'b1;
      cyc(3);
   endtask

   task automatic test_basic;
      bit ok1, ok2;
      int r0;
      got_q.delete();
      r0 = ack_rises;
      send_pair(8'h38, 8'h04, ok1);
      send_pair(8'h39, 8'h21, ok2);
      cyc(6);
      n_checks++; if ((ok1 & ok2) !== 1'b1) $display("FAIL basic_handshake: got %b expected 1", ok1 & ok2); else n_pass++;
      n_checks++; if (got_q.size() !== 2) $display("FAIL basic_npairs: got %0d expected 2", got_q.size()); else n_pass++;
      if (got_q.size() == 2) begin
         n_checks++; if (got_q[0] !== 16'h3804) $display("FAIL basic_pair0: got %h expected 3804", got_q[0]); else n_pass++;
         n_checks++; if (got_q[1] !== 16'h3921) $display("FAIL basic_pair1: got %h expected 3921", got_q[1]); else n_pass++;
      end
      n_checks++; if (pair_cnt !== 16'd2) $display("FAIL basic_cnt: got %0d expected 2", pair_cnt); else n_pass++;
      n_checks++; if (ack_rises - r0 !== 4) $display("FAIL basic_acks: got %0d expected 4", ack_rises - r0); else n_pass++;
   endtask

   task automatic test_backpressure;
      bit ok1, ok2, ok3, ok4;
      got_q.delete();
      out_ready = 1'b0;
      send_pair(8'h70, 8'h00, ok1);
      cyc(3);
      n_checks++; if ({out_valid, out_tag, out_data} !== 17'h17000) $display("FAIL bp_first_held: got %h expected 17000", {out_valid, out_tag, out_data}); else n_pass++;
      send_byte(8'h71, 1'b0, ok2);
      GPIO_AD = 8'h55;
      REQ     = 2'b11;
      cyc(40);
      n_checks++; if (ACK !== 1'b0) $display("FAIL bp_no_ack: got %b expected 0", ACK); else n_pass++;
      n_checks++; if ({out_tag, out_data} !== 16'h7000) $display("FAIL bp_outs_stable: got %h expected 7000", {out_tag, out_data}); else n_pass++;
      out_ready = 1'b1;
      wait_ack(1'b1, ok3);
      @(posedge clk); #1;
      REQ = 2'b00;
      wait_ack(1'b0, ok4);
      cyc(5);
      n_checks++; if ((ok1 & ok2 & ok3 & ok4) !== 1'b1) $display("FAIL bp_handshake: got %b expected 1", ok1 & ok2 & ok3 & ok4); else n_pass++;
      n_checks++; if (got_q.size() !== 2) $display("FAIL bp_npairs: got %0d expected 2", got_q.size()); else n_pass++;
      if (got_q.size() == 2) begin
         n_checks++; if (got_q[0] !== 16'h7000) $display("FAIL bp_pair0: got %h expected 7000", got_q[0]); else n_pass++;
         n_checks++; if (got_q[1] !== 16'h7155) $display("FAIL bp_pair1: got %h expected 7155", got_q[1]); else n_pass++;
      end
      n_checks++; if ({out_valid, pair_cnt} !== {1'b0, 16'd4}) $display("FAIL bp_cnt: got valid=%b cnt=%0d expected valid=0 cnt=4", out_valid, pair_cnt); else n_pass++;
   endtask

   task automatic test_phase_err;
      bit ok1, ok2;
      int e0;
      got_q.delete();
      e0 = err_cnt;
      send_byte(8'h38, 1'b0, ok1);
      send_pair(8'h39, 8'h10, ok2);
      cyc(6);
      n_checks++; if (err_cnt - e0 !== 1) $display("FAIL perr_pulses: got %0d expected 1", err_cnt - e0); else n_pass++;
      n_checks++; if ((ok1 & ok2) !== 1'b1) $display("FAIL perr_handshake: got %b expected 1", ok1 & ok2); else n_pass++;
      n_checks++; if (got_q.size() !== 1 || got_q[0] !== 16'h3910) $display("FAIL perr_pair: got n=%0d first=%h expected n=1 first=3910", got_q.size(), got_q[0]); else n_pass++;
      n_checks++; if (pair_cnt !== 16'd5) $display("FAIL perr_cnt: got %0d expected 5", pair_cnt); else n_pass++;
   endtask

   task automatic test_timeout;
      bit ok1, ok2;
      int e0, hi;
      got_q.delete();
      e0 = err_cnt;
      GPIO_AD = 8'h70;
      REQ     = 2'b01;
      wait_ack(1'b1, ok1);
      hi = 0;
      while (ACK === 1'b1 && hi < 300) begin
         hi++;
         @(negedge clk);
      end
      n_checks++; if (hi !== 256) $display("FAIL to_ack_cycles: got %0d expected 256", hi); else n_pass++;
      n_checks++; if ({ACK, err} !== 2'b01) $display("FAIL to_err_ack: got ack=%b err=%b expected ack=0 err=1", ACK, err); else n_pass++;
      @(posedge clk); #1;
      REQ = 2'b00;
      cyc(10);
      send_pair(8'h71, 8'h22, ok2);
      cyc(6);
      n_checks++; if (err_cnt - e0 !== 1) $display("FAIL to_resync_err: got %0d expected 1", err_cnt - e0); else n_pass++;
      n_checks++; if ((ok1 & ok2) !== 1'b1 || got_q.size() !== 1 || got_q[0] !== 16'h7122) $display("FAIL to_next_pair: got ok=%b n=%0d first=%h expected ok=1 n=1 first=7122", ok1 & ok2, got_q.size(), got_q[0]); else n_pass++;
      n_checks++; if (pair_cnt !== 16'd6) $display("FAIL to_cnt: got %0d expected 6", pair_cnt); else n_pass++;
   endtask

   task automatic test_filter;
      bit ok;
      int exp_n;
      logic [15:0] exp_cnt;
      got_q.delete();
      exp_n   = filt ? 0 : 1;
      exp_cnt = filt ? 16'd6 : 16'd7;
      send_pair(8'h12, 8'h34, ok);
      cyc(6);
      n_checks++; if (ok !== 1'b1) $display("FAIL filt_ack: got %b expected 1", ok); else n_pass++;
      n_checks++; if (got_q.size() !== exp_n) $display("FAIL filt_npairs: got %0d expected %0d", got_q.size(), exp_n); else n_pass++;
      if (got_q.size() == 1) begin
         n_checks++; if (got_q[0] !== 16'h1234) $display("FAIL filt_pair: got %h expected 1234", got_q[0]); else n_pass++;
      end
      n_checks++; if (pair_cnt !== exp_cnt) $display("FAIL filt_cnt: got %0d expected %0d", pair_cnt, exp_cnt); else n_pass++;
   endtask

   task automatic test_reset_mid;
      bit ok1, ok2;
      got_q.delete();
      GPIO_AD = 8'h38;
      REQ     = 2'b01;
      wait_ack(1'b1, ok1);
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if ({ACK, out_valid} !== 2'b00) $display("FAIL rmid_async: got ack=%b valid=%b expected 0 0", ACK, out_valid); else n_pass++;
      n_checks++; if (pair_cnt !== 16'd0) $display("FAIL rmid_cnt_clr: got %0d expected 0", pair_cnt); else n_pass++;
      REQ = 2'b00;
      cyc(3);
      rst_n = 1'b1;
      cyc(3);
      send_pair(8'h39, 8'h66, ok2);
      cyc(6);
      n_checks++; if ((ok1 & ok2) !== 1'b1 || got_q.size() !== 1 || got_q[0] !== 16'h3966) $display("FAIL rmid_pair: got ok=%b n=%0d first=%h expected ok=1 n=1 first=3966", ok1 & ok2, got_q.size(), got_q[0]); else n_pass++;
      n_checks++; if (pair_cnt !== 16'd1) $display("FAIL rmid_cnt: got %0d expected 1", pair_cnt); else n_pass++;
   endtask

   initial begin
`ifdef PI_LINK_TAG_FILTER_EN
      filt = 1'b1;
`else
      filt = 1'b0;
`endif
      test_reset();
      test_basic();
      test_backpressure();
      test_phase_err();
      test_timeout();
      test_filter();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
